// File: rtl/i2si_pkg.sv
// Shared constants for the I2S-in receive path.
package i2si_pkg;

    localparam int I2SI_DATA_W     = 32;
    localparam int I2SI_FIFO_DEPTH = 8;
    localparam int I2SI_FIFO_AW    = 3;

    typedef enum logic {
        SRC_SERIAL = 1'b0,
        SRC_BIST   = 1'b1
    } src_e;

endpackage

// File: rtl/i2si_fifo_mem.sv
// FIFO storage: register array, synchronous write, combinational read, no reset.
module i2si_fifo_mem
    import i2si_pkg::*;
#(
    parameter int DATA_W = I2SI_DATA_W,
    parameter int DEPTH  = I2SI_FIFO_DEPTH,
    parameter int ADDR_W = I2SI_FIFO_AW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/i2si_rx_fifo.sv
// I2S-in receive FIFO: source select, push/pop control, level and sticky overflow.
module i2si_rx_fifo
    import i2si_pkg::*;
#(
    parameter int DATA_W = I2SI_DATA_W,
    parameter int DEPTH  = I2SI_FIFO_DEPTH,
    parameter int ADDR_W = I2SI_FIFO_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rf_bist_en,
    input  logic              rf_fifo_clr,
    input  logic              rf_ovf_clr,
    input  logic [DATA_W-1:0] i2si_rx_data,
    input  logic              i2si_rx_xfc,
    input  logic [DATA_W-1:0] i2si_bist_out_data,
    input  logic              i2si_bist_out_xfc,
    input  logic              fifo_rd_rdy,
    output logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_rd_vld,
    output logic [ADDR_W:0]   fifo_level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              i2si_ovf
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    src_e              src_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [DATA_W-1:0] head_q;
    logic              ovf_q;

    logic [DATA_W-1:0] wr_data;
    logic              wr_req;
    logic              flush;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] rd_ptr_nxt;
    logic [ADDR_W:0]   level_nxt;
    logic [DATA_W-1:0] mem_rdata;
    logic              head_load;
    logic [DATA_W-1:0] head_nxt;

    assign fifo_full   = (level == FULL_LVL);
    assign fifo_empty  = (level == '0);
    assign fifo_rd_vld = !fifo_empty;
    assign fifo_level  = level;
    assign fifo_rd_data = head_q;
    assign i2si_ovf    = ovf_q;

    always_comb begin
        wr_data    = rf_bist_en ? i2si_bist_out_data : i2si_rx_data;
        wr_req     = rf_bist_en ? i2si_bist_out_xfc  : i2si_rx_xfc;
        flush      = rf_fifo_clr || (src_q != src_e'(rf_bist_en));
        pop        = fifo_rd_vld && fifo_rd_rdy;
        push       = wr_req && (!fifo_full || pop);
        rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
        level_nxt  = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
        // The registered head must already show a word written this same cycle.
        head_load = (pop && level_nxt != '0) || (fifo_empty && push);
        head_nxt  = (push && wr_ptr == rd_ptr_nxt) ? wr_data : mem_rdata;
    end

    i2si_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr_nxt),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= SRC_SERIAL;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            src_q <= src_e'(rf_bist_en);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                rd_ptr <= rd_ptr_nxt;
                level  <= level_nxt;
                if (head_load) begin
                    head_q <= head_nxt;
                end
            end
            if (!flush && wr_req && fifo_full && !pop) begin
                ovf_q <= 1'b1;
            end else if (rf_ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2si_rx_fifo.sv
// Directed bench for i2si_rx_fifo with hand-computed expectations.
module tb_i2si_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_bist_en;
    logic        rf_fifo_clr;
    logic        rf_ovf_clr;
    logic [31:0] i2si_rx_data;
    logic        i2si_rx_xfc;
    logic [31:0] i2si_bist_out_data;
    logic        i2si_bist_out_xfc;
    logic        fifo_rd_rdy;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_vld;
    logic [3:0]  fifo_level;
    logic        fifo_full;
    logic        fifo_empty;
    logic        i2si_ovf;

    int vectors   = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    i2si_rx_fifo dut (
        .clk                (clk),
        .rst                (rst),
        .rf_bist_en         (rf_bist_en),
        .rf_fifo_clr        (rf_fifo_clr),
        .rf_ovf_clr         (rf_ovf_clr),
        .i2si_rx_data       (i2si_rx_data),
        .i2si_rx_xfc        (i2si_rx_xfc),
        .i2si_bist_out_data (i2si_bist_out_data),
        .i2si_bist_out_xfc  (i2si_bist_out_xfc),
        .fifo_rd_rdy        (fifo_rd_rdy),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_rd_vld        (fifo_rd_vld),
        .fifo_level         (fifo_level),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .i2si_ovf           (i2si_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int lvl, input logic vld,
                             input logic full, input logic ovf);
        chk({tag, ".level"}, 32'(fifo_level), 32'(lvl));
        chk({tag, ".vld"},   32'(fifo_rd_vld), 32'(vld));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(!vld));
        chk({tag, ".full"},  32'(fifo_full), 32'(full));
        chk({tag, ".ovf"},   32'(i2si_ovf), 32'(ovf));
    endtask

    task automatic rx_push(input logic [31:0] d);
        i2si_rx_data = d;
        i2si_rx_xfc  = 1'b1;
        step();
        i2si_rx_xfc  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rf_bist_en = 1'b0; rf_fifo_clr = 1'b0; rf_ovf_clr = 1'b0;
        i2si_rx_data = '0; i2si_rx_xfc = 1'b0;
        i2si_bist_out_data = '0; i2si_bist_out_xfc = 1'b0; fifo_rd_rdy = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_state("reset", 0, 0, 0, 0);
        chk("reset.data", fifo_rd_data, 32'h0);

        // 1: three words, then pop in order
        rx_push(32'h11);
        chk_state("t1.first", 1, 1, 0, 0);
        chk("t1.first.data", fifo_rd_data, 32'h11);
        rx_push(32'h22);
        rx_push(32'h33);
        chk_state("t1.three", 3, 1, 0, 0);
        chk("t1.hold.data", fifo_rd_data, 32'h11);
        step();
        chk("t1.stall.data", fifo_rd_data, 32'h11);
        fifo_rd_rdy = 1'b1;
        step();
        chk("t1.pop1.data", fifo_rd_data, 32'h22);
        step();
        chk("t1.pop2.data", fifo_rd_data, 32'h33);
        chk("t1.pop2.level", 32'(fifo_level), 32'd1);
        step();
        fifo_rd_rdy = 1'b0;
        chk_state("t1.drained", 0, 0, 0, 0);

        // 2: fill, overflow, drain only the first eight
        for (int i = 0; i < 8; i++) rx_push(32'(i));
        chk_state("t2.full", 8, 1, 1, 0);
        rx_push(32'hAA);
        chk_state("t2.ovf", 8, 1, 1, 1);
        fifo_rd_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2.drain%0d", i), fifo_rd_data, 32'(i));
            step();
        end
        fifo_rd_rdy = 1'b0;
        chk_state("t2.empty", 0, 0, 0, 1);
        rf_ovf_clr = 1'b1;
        step();
        rf_ovf_clr = 1'b0;
        chk("t2.ovfclr", 32'(i2si_ovf), 32'd0);

        // 3: full with simultaneous push and pop
        for (int i = 0; i < 8; i++) rx_push(32'(i));
        fifo_rd_rdy = 1'b1;
        rx_push(32'hBB);
        fifo_rd_rdy = 1'b0;
        chk_state("t3.pushpop", 8, 1, 1, 0);
        chk("t3.head", fifo_rd_data, 32'h1);
        fifo_rd_rdy = 1'b1;
        for (int i = 1; i < 8; i++) step();
        chk("t3.last", fifo_rd_data, 32'hBB);
        step();
        fifo_rd_rdy = 1'b0;
        chk_state("t3.empty", 0, 0, 0, 0);

        // 4: BIST source, unselected xfc ignored, switch flushes
        rf_bist_en = 1'b1;
        step();
        chk("t4.switch.level", 32'(fifo_level), 32'd0);
        i2si_bist_out_data = 32'h064; i2si_bist_out_xfc = 1'b1;
        i2si_rx_data = 32'h999; i2si_rx_xfc = 1'b1;
        step();
        i2si_rx_xfc = 1'b0;
        chk_state("t4.bist1", 1, 1, 0, 0);
        chk("t4.bist1.data", fifo_rd_data, 32'h064);
        i2si_bist_out_data = 32'h065;
        step();
        i2si_bist_out_xfc = 1'b0;
        chk("t4.bist2.level", 32'(fifo_level), 32'd2);
        i2si_rx_data = 32'h777; i2si_rx_xfc = 1'b1;
        rf_bist_en = 1'b0;
        step();
        i2si_rx_xfc = 1'b0;
        chk_state("t4.flush", 0, 0, 0, 0);
        chk("t4.flush.data", fifo_rd_data, 32'h064);

        // 5: overflow set beats clear, then clear alone
        for (int i = 0; i < 8; i++) rx_push(32'h100 + 32'(i));
        rx_push(32'hE1);
        chk("t5.set", 32'(i2si_ovf), 32'd1);
        rf_ovf_clr = 1'b1;
        rx_push(32'hE2);
        chk("t5.setwins", 32'(i2si_ovf), 32'd1);
        step();
        rf_ovf_clr = 1'b0;
        chk("t5.clr", 32'(i2si_ovf), 32'd0);
        chk("t5.level", 32'(fifo_level), 32'd8);
        rf_fifo_clr = 1'b1;
        step();
        rf_fifo_clr = 1'b0;
        chk_state("t5.fifoclr", 0, 0, 0, 0);
        chk("t5.fifoclr.data", fifo_rd_data, 32'h100);

        // 6: reset mid-stream, then write right after
        for (int i = 0; i < 5; i++) rx_push(32'h200 + 32'(i));
        chk("t6.pre.level", 32'(fifo_level), 32'd5);
        rst = 1'b1; fifo_rd_rdy = 1'b1; i2si_rx_xfc = 1'b1; i2si_rx_data = 32'h3;
        step();
        rst = 1'b0; fifo_rd_rdy = 1'b0;
        chk_state("t6.reset", 0, 0, 0, 0);
        chk("t6.reset.data", fifo_rd_data, 32'h0);
        i2si_rx_data = 32'h55;
        step();
        i2si_rx_xfc = 1'b0;
        chk_state("t6.write", 1, 1, 0, 0);
        chk("t6.write.data", fifo_rd_data, 32'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2si_rx_fifo.md
Name: i2si_rx_fifo

Overview:
Consumer stage directly downstream of the I2S-in BIST generator and the I2S serial deserializer.
- Selects the word source: BIST when rf_bist_en=1, otherwise the serial path.
- Writes each word into a small FIFO on its transfer-complete pulse.
- Drains the FIFO through a valid/ready interface to the bus/DMA side.
- Reports FIFO level, full/empty and a sticky overflow flag to the register file.

Parameters:
DATA_W, 32, word width (matches BIST/deserializer output)
DEPTH, 8, FIFO entries (power of two, >=2)
ADDR_W, 3, log2(DEPTH)

Ports:
clk  in  1  master clock
rst  in  1  reset, synchronous, active-high
rf_bist_en  in  1  source select: 1=BIST, 0=serial
rf_fifo_clr  in  1  synchronous flush pulse
rf_ovf_clr  in  1  clears sticky overflow
i2si_rx_data  in  DATA_W  deserialized audio word
i2si_rx_xfc  in  1  1-cycle pulse, rx word valid
i2si_bist_out_data  in  DATA_W  BIST sawtooth word
i2si_bist_out_xfc  in  1  BIST transfer-complete pulse
fifo_rd_rdy  in  1  consumer ready
fifo_rd_data  out  DATA_W  head-of-FIFO word
fifo_rd_vld  out  1  head valid
fifo_level  out  ADDR_W+1  occupancy, 0..DEPTH
fifo_full  out  1  level==DEPTH
fifo_empty  out  1  level==0
i2si_ovf  out  1  sticky: a write was dropped

Behaviour:
- Single clock. The reset is synchronous and active-high.
- Reset values: level=0, rd/wr pointers=0, fifo_empty=1, fifo_full=0, fifo_rd_vld=0, fifo_rd_data=0, i2si_ovf=0, src_q=0.
- Source mux:
  - wr_data = rf_bist_en ? i2si_bist_out_data : i2si_rx_data
  - wr_req = rf_bist_en ? i2si_bist_out_xfc : i2si_rx_xfc
  - The xfc of the unselected source is ignored.
- src_q registers rf_bist_en every cycle. When rf_bist_en != src_q, that cycle is a source switch: treat it exactly like rf_fifo_clr. The wr_req in that cycle is dropped without setting i2si_ovf.
- Priority: rst > (rf_fifo_clr | source switch) > read/write.
- A flush sets pointers and level to 0 and fifo_rd_vld to 0 next cycle. fifo_rd_data holds its last value. i2si_ovf is not affected.
- Pop occurs when fifo_rd_vld && fifo_rd_rdy. The rd pointer advances by 1, modulo DEPTH.
- Push occurs when wr_req && (!fifo_full || pop). The word is written at the wr pointer, which then advances modulo DEPTH.
- Full with simultaneous push and pop: both are accepted and level stays at DEPTH.
- Empty with wr_req: no pop is possible. Level becomes 1 and fifo_rd_vld rises the next cycle. Write-to-valid latency is 1 cycle; there is no fall-through.
- Level update: +1 on push only, -1 on pop only, unchanged on both or neither.
- fifo_full, fifo_empty and fifo_rd_vld (= !empty) are derived from the registered level.
- fifo_rd_data is always the entry at the rd pointer. It updates the cycle after a pop or after the first write into an empty FIFO.
- fifo_rd_data must stay stable while fifo_rd_vld=1 and fifo_rd_rdy=0.
- Overflow: when wr_req && fifo_full && !pop, the word is dropped and i2si_ovf is set next cycle.
  - rf_ovf_clr clears i2si_ovf.
  - A set and a clear in the same cycle: set wins.
- Pointers wrap silently. There are no underflow effects because a pop requires vld.
- Reset asserted mid-stream returns every output to its reset value next cycle, whatever the other inputs are.

Decomposition:
- Shared package i2si_pkg:
  - I2SI_DATA_W=32
  - I2SI_FIFO_DEPTH=8
  - I2SI_FIFO_AW=3
  - source-select encoding SRC_SERIAL=0, SRC_BIST=1
- One sub-module, i2si_fifo_mem: a DEPTH x DATA_W register array with synchronous write port (we, waddr, wdata) and combinational read (raddr -> rdata). It has no reset on the storage.
- Pointer, level, mux, switch detection and overflow logic live in i2si_rx_fifo.

Test Plan:
1. rf_bist_en=0, 3 rx_xfc pulses with words 0x11,0x22,0x33, rdy=0 -> level=3, rd_data=0x11, vld=1. Then rdy=1 for 3 cycles -> 0x11,0x22,0x33 popped in order, empty=1.
2. Fill with 8 rx words (0..7), then a 9th (0xAA) with rdy=0 -> full=1, i2si_ovf=1, level=8. Drain -> 0..7 only, no 0xAA.
3. Full FIFO with wr_req and rdy=1 in the same cycle -> level stays 8, i2si_ovf stays 0, new word appears as the last entry.
4. rf_bist_en=1, BIST xfc with data 0x064 while rx_xfc also pulses with 0x999 -> only 0x064 stored. Toggle rf_bist_en to 0 with level=2 -> next cycle level=0, vld=0, i2si_ovf unchanged.
5. Set ovf, then assert rf_ovf_clr in the same cycle as a new overflow -> i2si_ovf stays 1. rf_ovf_clr alone -> 0.
6. rst=1 for 1 cycle with level=5 and rf_fifo_clr=0 -> all outputs at reset values next cycle. A write on the first cycle after reset -> vld=1 one cycle later.
